// File: rtl/fifo_n_oc_pkg.sv
// fifo_n_oc_pkg: shared defaults and width helpers for the fifo_n_oc slice.
package fifo_n_oc_pkg;
  localparam int DEF_WIDTH = 96;
  localparam int DEF_DEPTH = 4;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/fifo_n_oc_ptr_wrap.sv
// fifo_n_oc_ptr_wrap: pointer register with increment enable, sync clear and modulo-DEPTH wrap.
module fifo_n_oc_ptr_wrap
  import fifo_n_oc_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/fifo_n_oc.sv
// fifo_n_oc: N-entry guarded FIFO with occupancy count, almost_full flag and sync clear.
module fifo_n_oc
  import fifo_n_oc_pkg::*;
#(
  parameter  int WIDTH       = DEF_WIDTH,
  parameter  int DEPTH       = DEF_DEPTH,
  parameter  int ALMOST_FULL = DEPTH - 1,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_enq__ENA,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq__RDY,
  input  logic             out_deq__ENA,
  output logic             out_deq__RDY,
  output logic [WIDTH-1:0] out_first,
  output logic             out_first__RDY,
  input  logic             clear__ENA,
  output logic [CW-1:0]    count,
  output logic             almost_full
);
  localparam int PW = ptr_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic full, empty, enq, deq;
  assign full           = count == CW'(DEPTH);
  assign empty          = count == '0;
  assign enq            = in_enq__ENA & ~full & ~clear__ENA;
  assign deq            = out_deq__ENA & ~empty & ~clear__ENA;
  assign in_enq__RDY    = ~full;
  assign out_deq__RDY   = ~empty;
  assign out_first__RDY = ~empty;
  assign out_first      = mem[head];
  assign almost_full    = count >= CW'(ALMOST_FULL);
  fifo_n_oc_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_head (
    .CLK(CLK), .nRST(nRST), .clr(clear__ENA), .inc(deq), .ptr(head)
  );
  fifo_n_oc_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_tail (
    .CLK(CLK), .nRST(nRST), .clr(clear__ENA), .inc(enq), .ptr(tail)
  );
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) count <= '0;
    else count <= clear__ENA ? '0 : count + CW'(enq) - CW'(deq);
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (enq) mem[tail] <= in_enq_v;
endmodule

// File: tb/tb_fifo_n_oc.sv
// tb_fifo_n_oc: directed checks of fifo_n_oc at DEPTH=4/WIDTH=96 and a wrap run at DEPTH=3.
module tb_fifo_n_oc;
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic a_enq, a_deq, a_clr, a_enq_rdy, a_deq_rdy, a_first_rdy, a_af;
  logic [95:0] a_v, a_first;
  logic [2:0] a_cnt;
  logic b_enq, b_deq, b_clr, b_enq_rdy, b_deq_rdy, b_first_rdy, b_af;
  logic [7:0] b_v, b_first;
  logic [1:0] b_cnt;

  fifo_n_oc #(.WIDTH(96), .DEPTH(4)) dut_a (
    .CLK(clk), .nRST(nrst),
    .in_enq__ENA(a_enq), .in_enq_v(a_v), .in_enq__RDY(a_enq_rdy),
    .out_deq__ENA(a_deq), .out_deq__RDY(a_deq_rdy),
    .out_first(a_first), .out_first__RDY(a_first_rdy),
    .clear__ENA(a_clr), .count(a_cnt), .almost_full(a_af)
  );
  fifo_n_oc #(.WIDTH(8), .DEPTH(3)) dut_b (
    .CLK(clk), .nRST(nrst),
    .in_enq__ENA(b_enq), .in_enq_v(b_v), .in_enq__RDY(b_enq_rdy),
    .out_deq__ENA(b_deq), .out_deq__RDY(b_deq_rdy),
    .out_first(b_first), .out_first__RDY(b_first_rdy),
    .clear__ENA(b_clr), .count(b_cnt), .almost_full(b_af)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  int nb;
  logic e, d;

  initial begin
    nrst = 1'b0;
    {a_enq, a_deq, a_clr, b_enq, b_deq, b_clr} = '0;
    a_v = '0;
    b_v = '0;
    #23;
    chk("rst_enq_rdy", 96'(a_enq_rdy), 96'(1));
    chk("rst_deq_rdy", 96'(a_deq_rdy), 96'(0));
    chk("rst_first_rdy", 96'(a_first_rdy), 96'(0));
    chk("rst_first", a_first, 96'(0));
    chk("rst_count", 96'(a_cnt), 96'(0));
    chk("rst_af", 96'(a_af), 96'(0));
    nrst = 1'b1;
    cyc();
    chk("idle_enq_rdy", 96'(a_enq_rdy), 96'(1));
    chk("idle_count", 96'(a_cnt), 96'(0));
    // fill with 1..4
    for (int i = 1; i <= 4; i++) begin
      a_enq = 1'b1;
      a_v = 96'(i);
      cyc();
      a_enq = 1'b0;
      chk("fill_count", 96'(a_cnt), 96'(i));
      chk("fill_af", 96'(a_af), 96'(i >= 3));
      chk("fill_enq_rdy", 96'(a_enq_rdy), 96'(i < 4));
      chk("fill_first", a_first, 96'(1));
    end
    a_enq = 1'b1;
    a_v = 96'h5;
    cyc();
    a_enq = 1'b0;
    chk("full_enq_count", 96'(a_cnt), 96'(4));
    chk("full_enq_first", a_first, 96'(1));
    for (int i = 1; i <= 4; i++) begin
      chk("drain_first", a_first, 96'(i));
      chk("drain_first_rdy", 96'(a_first_rdy), 96'(1));
      a_deq = 1'b1;
      cyc();
      a_deq = 1'b0;
      chk("drain_count", 96'(a_cnt), 96'(4 - i));
    end
    chk("empty_deq_rdy", 96'(a_deq_rdy), 96'(0));
    chk("empty_af", 96'(a_af), 96'(0));
    a_deq = 1'b1;
    cyc();
    a_deq = 1'b0;
    chk("empty_deq_count", 96'(a_cnt), 96'(0));
    // refill, then enq+deq at full: only the deq happens
    for (int i = 0; i < 4; i++) begin
      a_enq = 1'b1;
      a_v = 96'h10 + 96'(i);
      cyc();
    end
    a_v = 96'h99;
    a_deq = 1'b1;
    cyc();
    {a_enq, a_deq} = '0;
    chk("full_both_count", 96'(a_cnt), 96'(3));
    chk("full_both_first", a_first, 96'h11);
    a_deq = 1'b1;
    cyc();
    a_deq = 1'b0;
    chk("pre_sim_count", 96'(a_cnt), 96'(2));
    a_enq = 1'b1;
    a_deq = 1'b1;
    a_v = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
    cyc();
    {a_enq, a_deq} = '0;
    chk("sim_count", 96'(a_cnt), 96'(2));
    chk("sim_first", a_first, 96'h13);
    a_deq = 1'b1;
    cyc();
    a_deq = 1'b0;
    chk("sim_tail", a_first, 96'hDEAD_BEEF_0123_4567_89AB_CDEF);
    chk("sim_tail_count", 96'(a_cnt), 96'(1));
    a_enq = 1'b1;
    a_v = 96'h30;
    cyc();
    a_v = 96'h31;
    cyc();
    a_enq = 1'b0;
    chk("pre_clr_count", 96'(a_cnt), 96'(3));
    a_clr = 1'b1;
    a_enq = 1'b1;
    a_deq = 1'b1;
    a_v = 96'h77;
    cyc();
    {a_clr, a_enq, a_deq} = '0;
    chk("clr_count", 96'(a_cnt), 96'(0));
    chk("clr_first_rdy", 96'(a_first_rdy), 96'(0));
    chk("clr_enq_rdy", 96'(a_enq_rdy), 96'(1));
    a_enq = 1'b1;
    a_v = 96'h40;
    cyc();
    a_v = 96'h41;
    cyc();
    a_enq = 1'b0;
    chk("post_clr_first", a_first, 96'h40);
    chk("post_clr_count", 96'(a_cnt), 96'(2));
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_count", 96'(a_cnt), 96'(0));
    chk("mid_rst_first", a_first, 96'(0));
    chk("mid_rst_first_rdy", 96'(a_first_rdy), 96'(0));
    chk("mid_rst_enq_rdy", 96'(a_enq_rdy), 96'(1));
    nrst = 1'b1;
    a_enq = 1'b1;
    a_v = 96'hAB;
    cyc();
    a_enq = 1'b0;
    chk("after_rst_first", a_first, 96'hAB);
    chk("after_rst_count", 96'(a_cnt), 96'(1));
    // DEPTH=3 wrap run against a queue model
    nb = 1;
    for (int k = 0; k < 10; k++) begin
      e = q.size() < 3;
      d = q.size() > 0 && (k % 3 != 2);
      b_enq = 1'b1;
      b_deq = d;
      b_v = 8'(nb);
      cyc();
      if (d) void'(q.pop_front());
      if (e) q.push_back(8'(nb));
      nb++;
      chk("wrap_count", 96'(b_cnt), 96'(q.size()));
      if (q.size() > 0) chk("wrap_first", 96'(b_first), 96'(q[0]));
    end
    b_enq = 1'b0;
    while (q.size() > 0) begin
      chk("wrap_drain", 96'(b_first), 96'(q[0]));
      b_deq = 1'b1;
      cyc();
      void'(q.pop_front());
    end
    b_deq = 1'b0;
    chk("wrap_empty", 96'(b_deq_rdy), 96'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
